// File: rtl/uart_pkg.sv
// Shared UART definitions: byte width and the buffer sequencer state encoding.
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } buf_state_e;

endpackage : uart_pkg

// File: rtl/tx_byte_fifo.sv
// Single-clock byte FIFO with registered count/full/empty and a one-cycle overflow pulse.
module tx_byte_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              ovf
);

  logic [BYTE_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              accept_c;
  logic              pop_c;
  logic [AW:0]       count_d;

  // A full FIFO still takes a byte when the same cycle frees a slot.
  always_comb begin
    accept_c = push && (!full || pop);
    pop_c    = pop && !empty;
    count_d  = count;
    case ({accept_c, pop_c})
      2'b10:   count_d = count + (AW+1)'(1);
      2'b01:   count_d = count - (AW+1)'(1);
      default: count_d = count;
    endcase
  end

  assign dout = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (accept_c) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      ovf    <= 1'b0;
    end else begin
      if (accept_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)    rd_ptr <= rd_ptr + AW'(1);
      count <= count_d;
      full  <= (count_d == (AW+1)'(DEPTH));
      empty <= (count_d == '0);
      ovf   <= push && !accept_c;
    end
  end

endmodule : tx_byte_fifo

// File: rtl/tx_fifo_feeder.sv
// Buffers system-side bytes and sequences them into the UART transmit control stage
// using an enable-held-for-frame / done-pulse handshake.
module tx_fifo_feeder
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              Wr_En_Sig,
  input  logic [BYTE_W-1:0] Wr_Data,
  output logic              Full_Sig,
  output logic              Empty_Sig,
  output logic [AW:0]       Count,
  output logic              Ovf_Sig,
  output logic              TX_En_Sig,
  output logic [BYTE_W-1:0] TX_Data,
  input  logic              TX_Done_Sig
);

  buf_state_e        state_q;
  buf_state_e        state_d;
  logic              tx_en_d;
  logic [BYTE_W-1:0] tx_data_d;
  logic              pop_c;
  logic [BYTE_W-1:0] fifo_dout;

  tx_byte_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .CLK   (CLK),
    .RST   (RST),
    .push  (Wr_En_Sig),
    .pop   (pop_c),
    .din   (Wr_Data),
    .dout  (fifo_dout),
    .full  (Full_Sig),
    .empty (Empty_Sig),
    .count (Count),
    .ovf   (Ovf_Sig)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      TX_En_Sig <= 1'b0;
      TX_Data   <= '0;
    end else begin
      state_q   <= state_d;
      TX_En_Sig <= tx_en_d;
      TX_Data   <= tx_data_d;
    end
  end

  // Data only loads together with a rising enable, so it is frozen for the frame.
  always_comb begin
    state_d   = state_q;
    tx_en_d   = TX_En_Sig;
    tx_data_d = TX_Data;
    pop_c     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!Empty_Sig) begin
          pop_c     = 1'b1;
          tx_data_d = fifo_dout;
          tx_en_d   = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (TX_Done_Sig) begin
          tx_en_d = 1'b0;
          state_d = GAP;
        end
      end
      GAP: begin
        tx_en_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        tx_en_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

endmodule : tx_fifo_feeder
